ins_fetch: RTL and testbench

//  Instruction fetch/assembly stage. Sole driver of the program-counter increment.

---
 rtl/ins_fetch_if.sv | 32 +++
 rtl/ins_fetch.sv | 127 ++++++++++++
 tb/tb_ins_fetch.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_fetch_if.sv
// ============================================================================
// ins_fetch_if : memory read bus and instruction hand-off bundle for ins_fetch
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface ins_fetch_if;
  logic        o_mem_rd;
  logic [15:0] o_mem_addr;
  logic [7:0]  i_mem_data;
  logic        o_ins_valid;
  logic        i_ins_ready;
  logic [7:0]  o_ins_opcode;
  logic [15:0] o_ins_operand;
  logic [1:0]  o_ins_len;
  logic [15:0] o_ins_pc;

  // Names follow the fetch unit's point of view.
  modport master (
    output o_mem_rd, o_mem_addr, o_ins_valid, o_ins_opcode, o_ins_operand,
           o_ins_len, o_ins_pc,
    input  i_mem_data, i_ins_ready
  );

  modport slave (
    input  o_mem_rd, o_mem_addr, o_ins_valid, o_ins_opcode, o_ins_operand,
           o_ins_len, o_ins_pc,
    output i_mem_data, i_ins_ready
  );
endinterface

`default_nettype wire

// File: rtl/ins_fetch.sv
// ============================================================================
// ins_fetch : 6502 instruction fetch/assembly stage, one PC increment per read
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ins_fetch #(
  parameter int BRK_LEN = 1
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic [15:0] i_pc,
  output logic             o_pc_inc,
  input  wire logic        i_redirect,
  ins_fetch_if.master      bus
);

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_FOPC = 3'd1;
  localparam logic [2:0] S_COPC = 3'd2;
  localparam logic [2:0] S_COP1 = 3'd3;
  localparam logic [2:0] S_COP2 = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam logic [1:0] c_BRK_LEN = 2'(BRK_LEN);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        w_rd;
  logic        w_valid;
  logic [1:0]  w_len_new;
  logic [7:0]  r_opcode;
  logic [15:0] r_operand;
  logic [1:0]  r_len;
  logic [15:0] r_ins_pc;

  function automatic logic [1:0] f_len(input logic [7:0] op);
    logic [1:0] len;
    if (op[3:2] == 2'b11 || op == 8'h20 || (op[3:0] == 4'h9 && op[4]))
      len = 2'd3;
    else if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h40 || op == 8'h60)
      len = 2'd1;
    else if (op == 8'h00)
      len = c_BRK_LEN;
    else
      len = 2'd2;
    return len;
  endfunction

  assign w_len_new = f_len(bus.i_mem_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= S_RST;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_FOPC;
      S_FOPC:  w_next = S_COPC;
      S_COPC:  w_next = (w_len_new >= 2'd2) ? S_COP1 : S_HOLD;
      S_COP1:  w_next = (r_len == 2'd3) ? S_COP2 : S_HOLD;
      S_COP2:  w_next = S_HOLD;
      S_HOLD:  w_next = bus.i_ins_ready ? S_COPC : S_HOLD;
      default: w_next = S_RST;
    endcase
    // A PC load restarts the fetch regardless of progress.
    if (i_redirect)
      w_next = S_FOPC;
  end

  always_comb begin
    w_rd    = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_FOPC: w_rd = 1'b1;
      S_COPC: w_rd = (w_len_new >= 2'd2);
      S_COP1: w_rd = (r_len == 2'd3);
      S_HOLD: begin
        w_valid = 1'b1;
        w_rd    = bus.i_ins_ready;
      end
      default: w_rd = 1'b0;
    endcase
    if (i_redirect)
      w_rd = 1'b0;
  end

  // Data latching is suppressed on redirect so a dropped instruction never
  // disturbs the registered view.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opcode  <= 8'h00;
      r_operand <= 16'h0000;
      r_len     <= 2'd0;
      r_ins_pc  <= 16'h0000;
    end else if (!i_redirect) begin
      case (r_state)
        S_FOPC: r_ins_pc <= i_pc;
        S_COPC: begin
          r_opcode  <= bus.i_mem_data;
          r_len     <= w_len_new;
          r_operand <= 16'h0000;
        end
        S_COP1: r_operand[7:0]  <= bus.i_mem_data;
        S_COP2: r_operand[15:8] <= bus.i_mem_data;
        S_HOLD: if (bus.i_ins_ready) r_ins_pc <= i_pc;
        default: ;
      endcase
    end
  end

  assign o_pc_inc          = w_rd;
  assign bus.o_mem_rd      = w_rd;
  assign bus.o_mem_addr    = i_pc;
  assign bus.o_ins_valid   = w_valid;
  assign bus.o_ins_opcode  = r_opcode;
  assign bus.o_ins_operand = r_operand;
  assign bus.o_ins_len     = r_len;
  assign bus.o_ins_pc      = r_ins_pc;

endmodule

`default_nettype wire

// File: tb/tb_ins_fetch.sv
// ============================================================================
// tb_ins_fetch : directed vectors and handshake sequences for ins_fetch
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] new_pc = 16'h0000;
  logic        ready = 1'b0;
  logic [15:0] pc1, pc2;
  logic        pc_inc1, pc_inc2;
  logic [7:0]  d1, d2;
  logic [7:0]  mem [0:65535];
  int          n_pass = 0;
  int          n_total = 0;
  int          hs_cnt = 0;

  always #5 clk = ~clk;

  ins_fetch_if bus1();
  ins_fetch_if bus2();

  ins_fetch #(.BRK_LEN(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc1), .o_pc_inc(pc_inc1),
    .i_redirect(redirect), .bus(bus1)
  );

  ins_fetch #(.BRK_LEN(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc2), .o_pc_inc(pc_inc2),
    .i_redirect(redirect), .bus(bus2)
  );

  // PC register and single-cycle-latency memory for each instance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc1 <= 16'h0000;
      pc2 <= 16'h0000;
    end else begin
      if (redirect) pc1 <= new_pc; else if (pc_inc1) pc1 <= pc1 + 16'h1;
      if (redirect) pc2 <= new_pc; else if (pc_inc2) pc2 <= pc2 + 16'h1;
    end
  end

  always @(posedge clk) begin
    if (bus1.o_mem_rd) d1 <= mem[bus1.o_mem_addr];
    if (bus2.o_mem_rd) d2 <= mem[bus2.o_mem_addr];
    if (rst_n && bus1.o_ins_valid && ready) hs_cnt <= hs_cnt + 1;
  end

  assign bus1.i_mem_data  = d1;
  assign bus2.i_mem_data  = d2;
  assign bus1.i_ins_ready = ready;
  assign bus2.i_ins_ready = ready;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
    logic [15:0] endpc;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
    logic [15:0] pc;
  } ins_t;

  vec_t vecs[9];
  ins_t stream_exp[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int exp_len(input int op, input int brk);
    int lo;
    lo = op % 16;
    if (op == 0) return brk;
    if (op == 32) return 3;
    case (lo)
      12, 13, 14, 15: return 3;
      9:              return ((op / 16) % 2 == 1) ? 3 : 2;
      8, 10:          return 1;
      default:        return (op == 64 || op == 96) ? 1 : 2;
    endcase
  endfunction

  task automatic pulse_redirect(input logic [15:0] pc);
    redirect = 1'b1;
    new_pc   = pc;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic wait_v1(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus1.o_ins_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_ins(input string name, input logic [7:0] op, input logic [15:0] opnd,
                         input logic [1:0] len, input logic [15:0] pc);
    chk({name, "_opcode"},  32'(bus1.o_ins_opcode),  32'(op));
    chk({name, "_operand"}, 32'(bus1.o_ins_operand), 32'(opnd));
    chk({name, "_len"},     32'(bus1.o_ins_len),     32'(len));
    chk({name, "_pc"},      32'(bus1.o_ins_pc),      32'(pc));
  endtask

  initial begin
    int hs_cyc[3];
    int k, cyc, first4c, hs0;
    bit bp_done, ok;

    vecs[0] = '{16'h0100, 8'hA9, 8'h42, 8'hEA, 8'hA9, 16'h0042, 2'd2, 16'h0102};
    vecs[1] = '{16'h1000, 8'hEA, 8'hFF, 8'hFF, 8'hEA, 16'h0000, 2'd1, 16'h1001};
    vecs[2] = '{16'h2000, 8'h4C, 8'h34, 8'h12, 8'h4C, 16'h1234, 2'd3, 16'h2003};
    vecs[3] = '{16'hFFFE, 8'h20, 8'h00, 8'hC0, 8'h20, 16'hC000, 2'd3, 16'h0001};
    vecs[4] = '{16'h3000, 8'h60, 8'hAA, 8'hBB, 8'h60, 16'h0000, 2'd1, 16'h3001};
    vecs[5] = '{16'h3100, 8'h00, 8'hAA, 8'hBB, 8'h00, 16'h0000, 2'd1, 16'h3101};
    vecs[6] = '{16'h3200, 8'h09, 8'h10, 8'h20, 8'h09, 16'h0010, 2'd2, 16'h3202};
    vecs[7] = '{16'h3300, 8'hA2, 8'h05, 8'h99, 8'hA2, 16'h0005, 2'd2, 16'h3302};
    vecs[8] = '{16'h3400, 8'h19, 8'h33, 8'h44, 8'h19, 16'h4433, 2'd3, 16'h3403};

    stream_exp[0] = '{8'hA9, 16'h0042, 2'd2, 16'h0000};
    stream_exp[1] = '{8'hEA, 16'h0000, 2'd1, 16'h0002};
    stream_exp[2] = '{8'h4C, 16'h1234, 2'd3, 16'h0003};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'hEA;
    mem[3] = 8'h4C; mem[4] = 8'h34; mem[5] = 8'h12;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus1.o_ins_valid), 32'd0);
    chk("rst_rd", 32'(bus1.o_mem_rd), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc1), 32'd0);
    chk_ins("rst", 8'h00, 16'h0000, 2'd0, 16'h0000);

    // Stream with backpressure on the third instruction
    rst_n = 1'b1;
    ready = 1'b1;
    #1 chk("cycle1_rd", 32'(bus1.o_mem_rd), 32'd0);
    @(negedge clk);
    chk("first_rd", 32'(bus1.o_mem_rd), 32'd1);
    chk("first_addr", 32'(bus1.o_mem_addr), 32'h0000);
    cyc = 2; k = 0; bp_done = 1'b0; first4c = 0;
    while (k < 3 && cyc < 60) begin
      if (bus1.o_ins_valid) begin
        chk_ins($sformatf("stream%0d", k), stream_exp[k].op, stream_exp[k].opnd,
                stream_exp[k].len, stream_exp[k].pc);
        if (k == 2 && !bp_done) begin
          first4c = cyc;
          ready = 1'b0;
          for (int j = 0; j < 5; j++) begin
            @(negedge clk); cyc++;
            chk("bp_valid", 32'(bus1.o_ins_valid), 32'd1);
            chk("bp_opcode", 32'(bus1.o_ins_opcode), 32'h4C);
            chk("bp_operand", 32'(bus1.o_ins_operand), 32'h1234);
            chk("bp_pc_inc", 32'(pc_inc1), 32'd0);
            chk("bp_pc", 32'(pc1), 32'h0006);
          end
          ready = 1'b1;
          bp_done = 1'b1;
          #1;
          chk("bp_release_rd", 32'(bus1.o_mem_rd), 32'd1);
          chk("bp_release_addr", 32'(bus1.o_mem_addr), 32'h0006);
        end
        if (ready) begin hs_cyc[k] = cyc; k++; end
      end
      @(negedge clk); cyc++;
    end
    chk("stream_count", 32'(k), 32'd3);
    chk("gap_a9", 32'(hs_cyc[0] - 2), 32'd3);
    chk("gap_ea", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
    chk("gap_4c", 32'(first4c - hs_cyc[1]), 32'd4);
    ready = 1'b0;
    @(negedge clk);

    // Redirect while collecting the first operand of 4C
    mem[16'h8000] = 8'hEA; mem[16'h8001] = 8'h77;
    pulse_redirect(16'h0003);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; new_pc = 16'h8000;
    #1;
    chk("redir_cop1_rd", 32'(bus1.o_mem_rd), 32'd0);
    chk("redir_cop1_inc", 32'(pc_inc1), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("redir_fopc_rd", 32'(bus1.o_mem_rd), 32'd1);
    chk("redir_fopc_addr", 32'(bus1.o_mem_addr), 32'h8000);
    wait_v1("redir_cop1");
    chk_ins("redir_cop1", 8'hEA, 16'h0000, 2'd1, 16'h8000);

    // Redirect coincident with a completing handshake
    mem[16'h9000] = 8'hEA;
    pulse_redirect(16'h0000);
    wait_v1("redir_hs");
    chk_ins("redir_hs_a9", 8'hA9, 16'h0042, 2'd2, 16'h0000);
    @(negedge clk);
    hs0 = hs_cnt;
    ready = 1'b1; redirect = 1'b1; new_pc = 16'h9000;
    #1;
    chk("redir_hs_rd", 32'(bus1.o_mem_rd), 32'd0);
    chk("redir_hs_valid", 32'(bus1.o_ins_valid), 32'd1);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("redir_hs_single", 32'(hs_cnt - hs0), 32'd1);
    chk("redir_hs_valid_after", 32'(bus1.o_ins_valid), 32'd0);
    chk("redir_hs_next_addr", 32'(bus1.o_mem_addr), 32'h9000);
    chk("redir_hs_next_rd", 32'(bus1.o_mem_rd), 32'd1);
    wait_v1("redir_hs_ea");
    chk_ins("redir_hs_ea", 8'hEA, 16'h0000, 2'd1, 16'h9000);
    ready = 1'b0;
    @(negedge clk);

    // Directed instruction table
    for (int v = 0; v < 9; v++) begin
      mem[vecs[v].pc]          = vecs[v].b0;
      mem[16'(vecs[v].pc + 1)] = vecs[v].b1;
      mem[16'(vecs[v].pc + 2)] = vecs[v].b2;
      pulse_redirect(vecs[v].pc);
      wait_v1($sformatf("vec%0d", v));
      chk_ins($sformatf("vec%0d", v), vecs[v].op, vecs[v].opnd, vecs[v].len, vecs[v].pc);
      chk($sformatf("vec%0d_endpc", v), 32'(pc1), 32'(vecs[v].endpc));
    end

    // Length sweep on both BRK_LEN settings
    mem[16'h4001] = 8'h11; mem[16'h4002] = 8'h22;
    for (int op = 0; op < 256; op++) begin
      mem[16'h4000] = 8'(op);
      pulse_redirect(16'h4000);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
        #1;
        if (bus1.o_ins_valid && bus2.o_ins_valid) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) chk($sformatf("sweep_%02h_timeout", op), 32'd0, 32'd1);
      chk($sformatf("len1_%02h", op), 32'(bus1.o_ins_len), 32'(exp_len(op, 1)));
      chk($sformatf("len2_%02h", op), 32'(bus2.o_ins_len), 32'(exp_len(op, 2)));
    end

    // Asynchronous reset while collecting the high operand byte
    mem[0] = 8'h4C; mem[1] = 8'h34; mem[2] = 8'h12;
    pulse_redirect(16'h0000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus1.o_ins_valid), 32'd0);
    chk("arst_rd", 32'(bus1.o_mem_rd), 32'd0);
    chk("arst_pc_inc", 32'(pc_inc1), 32'd0);
    chk_ins("arst", 8'h00, 16'h0000, 2'd0, 16'h0000);
    mem[0] = 8'hEA;
    @(negedge clk);
    rst_n = 1'b1;
    wait_v1("arst_refetch");
    chk_ins("arst_refetch", 8'hEA, 16'h0000, 2'd1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
